picnic_round_verify_seq: RTL and testbench

- Parametrised sequencer for one Picnic-on-SM4 verification round.
- Drives a shared external hash engine through a req/done handshake. The job order is: per-party commitments, then Cn, then Cv, then Ch.
- Latches every digest locally and presents the round results to the signature verifier top.
- Generalises the single-Cn round block: configurable party count, hidden-party substitution, and round-type selection (in LC / not in LC).

---
 rtl/picnic_round_pkg.sv | 24 ++
 rtl/picnic_round_verify_seq_hash_job_port.sv | 78 +++++++
 rtl/picnic_round_verify_seq.sv | 201 ++++++++++++++++++++
 tb/tb_picnic_round_verify_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/picnic_round_pkg.sv
// Shared types and constants for the Picnic-on-SM4 round verification sequencer.
package picnic_round_pkg;

    localparam int unsigned DEFAULT_DIGEST_W = 256;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_PARTY = 2'd0;
    localparam mode_t MODE_CN    = 2'd1;
    localparam mode_t MODE_CV    = 2'd2;
    localparam mode_t MODE_CH    = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StParty,
        StWait,
        StGap,
        StCn,
        StCv,
        StCh,
        StDone
    } state_e;

endpackage

// File: rtl/picnic_round_verify_seq_hash_job_port.sv
// Hash engine request port: registered req/mode/idx handshake plus, when
// ROUND_SEQ_TIMEOUT_EN is defined, a per-job watchdog.
module hash_job_port
    import picnic_round_pkg::*;
#(
    parameter int unsigned IDX_W          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue,
    input  mode_t            mode,
    input  logic [IDX_W-1:0] idx,
    input  logic             hash_done,
    output logic             hash_req,
    output mode_t            hash_mode,
    output logic [IDX_W-1:0] hash_idx,
    output logic             job_done,
    output logic             timeout
);

    logic             req_q, req_d;
    mode_t            mode_q;
    logic [IDX_W-1:0] idx_q;

    // A done pulse only counts while a request is outstanding.
    assign job_done = req_q && hash_done;

`ifdef ROUND_SEQ_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q;

    assign timeout = req_q && !hash_done && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (issue) begin
            cnt_q <= '0;
        end else if (req_q) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        req_d = req_q;
        if (issue) begin
            req_d = 1'b1;
        end else if (job_done || timeout) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q  <= 1'b0;
            mode_q <= MODE_PARTY;
            idx_q  <= '0;
        end else begin
            req_q <= req_d;
            if (issue) begin
                mode_q <= mode;
                idx_q  <= idx;
            end
        end
    end

    assign hash_req  = req_q;
    assign hash_mode = mode_q;
    assign hash_idx  = idx_q;

endmodule

// File: rtl/picnic_round_verify_seq.sv
// Sequencer for one Picnic-on-SM4 verification round: party commitments, then Cn, Cv, Ch.
// Optional per-job watchdog is enabled by defining ROUND_SEQ_TIMEOUT_EN.
module picnic_round_verify_seq
    import picnic_round_pkg::*;
#(
    parameter int unsigned NUM_PARTIES    = 16,
    parameter int unsigned DIGEST_W       = DEFAULT_DIGEST_W,
    parameter int unsigned IDX_W          = $clog2(NUM_PARTIES),
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            in_lc,
    input  logic [IDX_W-1:0]                hidden_j,
    input  logic [DIGEST_W-1:0]             com_hidden,
    output logic                            hash_req,
    output logic [1:0]                      hash_mode,
    output logic [IDX_W-1:0]                hash_idx,
    input  logic                            hash_done,
    input  logic [DIGEST_W-1:0]             hash_digest,
    output logic [NUM_PARTIES*DIGEST_W-1:0] com_all,
    output logic [DIGEST_W-1:0]             cn,
    output logic [DIGEST_W-1:0]             cv,
    output logic [DIGEST_W-1:0]             ch,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_PARTIES - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d, hidden_q, hidden_d;
    logic [DIGEST_W-1:0] com_hidden_q, com_hidden_d;
    logic [DIGEST_W-1:0] com_q [NUM_PARTIES];
    logic [DIGEST_W-1:0] com_d [NUM_PARTIES];
    logic [DIGEST_W-1:0] cn_q, cn_d, cv_q, cv_d, ch_q, ch_d;
    logic                accept, issue, job_done, timeout;
    mode_t               issue_mode;
    logic [IDX_W-1:0]    issue_idx;

    hash_job_port #(
        .IDX_W          (IDX_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_port (
        .clk       (clk),
        .reset     (reset),
        .issue     (issue),
        .mode      (issue_mode),
        .idx       (issue_idx),
        .hash_done (hash_done),
        .hash_req  (hash_req),
        .hash_mode (hash_mode),
        .hash_idx  (hash_idx),
        .job_done  (job_done),
        .timeout   (timeout)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        hidden_d     = hidden_q;
        com_hidden_d = com_hidden_q;
        com_d        = com_q;
        cn_d         = cn_q;
        cv_d         = cv_q;
        ch_d         = ch_q;
        accept       = 1'b0;
        issue        = 1'b0;
        issue_mode   = MODE_PARTY;
        issue_idx    = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept       = 1'b1;
                    hidden_d     = hidden_j;
                    com_hidden_d = com_hidden;
                    idx_d        = '0;
                    state_d      = in_lc ? StCn : StParty;
                end
            end
            StParty: begin
                if (idx_q == hidden_q) begin
                    // Unopened party: take the supplied commitment instead of hashing.
                    com_d[idx_q] = com_hidden_q;
                    if (idx_q == LastIdx) begin
                        state_d = StCn;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    issue     = 1'b1;
                    issue_idx = idx_q;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (job_done) begin
                    case (hash_mode)
                        MODE_PARTY: com_d[hash_idx] = hash_digest;
                        MODE_CN:    cn_d = hash_digest;
                        MODE_CV:    cv_d = hash_digest;
                        default:    ch_d = hash_digest;
                    endcase
                    state_d = StGap;
                end else if (timeout) begin
                    state_d = StDone;
                end
            end
            StGap: begin
                case (hash_mode)
                    MODE_PARTY: begin
                        if (idx_q == LastIdx) begin
                            state_d = StCn;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = StParty;
                        end
                    end
                    MODE_CN: state_d = StCv;
                    MODE_CV: state_d = StCh;
                    default: state_d = StDone;
                endcase
            end
            StCn: begin
                issue      = 1'b1;
                issue_mode = MODE_CN;
                state_d    = StWait;
            end
            StCv: begin
                issue      = 1'b1;
                issue_mode = MODE_CV;
                state_d    = StWait;
            end
            StCh: begin
                issue      = 1'b1;
                issue_mode = MODE_CH;
                state_d    = StWait;
            end
            StDone: begin
                if (!start) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            hidden_q     <= '0;
            com_hidden_q <= '0;
            com_q        <= '{default: '0};
            cn_q         <= '0;
            cv_q         <= '0;
            ch_q         <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            hidden_q     <= hidden_d;
            com_hidden_q <= com_hidden_d;
            com_q        <= com_d;
            cn_q         <= cn_d;
            cv_q         <= cv_d;
            ch_q         <= ch_d;
        end
    end

`ifdef ROUND_SEQ_TIMEOUT_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (state_q == StWait && timeout) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign err = 1'b0;
`endif

    for (genvar i = 0; i < NUM_PARTIES; i++) begin : g_com
        assign com_all[i*DIGEST_W +: DIGEST_W] = com_q[i];
    end

    assign cn   = cn_q;
    assign cv   = cv_q;
    assign ch   = ch_q;
    assign done = (state_q == StDone);
    assign busy = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_picnic_round_verify_seq.sv
// Randomized self-checking bench for picnic_round_verify_seq with a latency-programmable
// engine model; the watchdog scenario runs only when ROUND_SEQ_TIMEOUT_EN is defined.
module tb_picnic_round_verify_seq;
    import picnic_round_pkg::*;

    localparam int unsigned NP = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = $clog2(NP);
    localparam int unsigned TO = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             in_lc = 1'b0;
    logic [IW-1:0]    hidden_j = '0;
    logic [DW-1:0]    com_hidden = '0;
    logic             hash_req;
    logic [1:0]       hash_mode;
    logic [IW-1:0]    hash_idx;
    logic             hash_done;
    logic [DW-1:0]    hash_digest;
    logic [NP*DW-1:0] com_all;
    logic [DW-1:0]    cn, cv, ch;
    logic             busy, done, err;

    always #5 clk = ~clk;

    picnic_round_verify_seq #(
        .NUM_PARTIES    (NP),
        .DIGEST_W       (DW),
        .IDX_W          (IW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_lc       (in_lc),
        .hidden_j    (hidden_j),
        .com_hidden  (com_hidden),
        .hash_req    (hash_req),
        .hash_mode   (hash_mode),
        .hash_idx    (hash_idx),
        .hash_done   (hash_done),
        .hash_digest (hash_digest),
        .com_all     (com_all),
        .cn          (cn),
        .cv          (cv),
        .ch          (ch),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // Engine model: done pulses L cycles after req rises; digest = salt ^ {mode, idx}.
    int unsigned   lat = 3;
    bit            eng_hang = 1'b0;
    bit            spur_en = 1'b0;
    bit            force_spur = 1'b0;
    int            eng_cnt = 0;
    logic          eng_done = 1'b0;
    logic          spur = 1'b0;
    logic          req_prev = 1'b0;
    logic [DW-1:0] salt = '0;
    logic [DW-1:0] junk = '0;
    int            jobs[$];

    function automatic logic [DW-1:0] dig(input logic [1:0] m, input int i);
        logic [7:0] i8;
        i8 = 8'(i);
        return salt ^ {{(DW-10){1'b0}}, m, i8};
    endfunction

    assign hash_done   = eng_done | spur;
    assign hash_digest = eng_done ? dig(hash_mode, int'(hash_idx)) : junk;

    always @(negedge clk) begin
        if (hash_req && !req_prev) jobs.push_back(int'(hash_mode) * 256 + int'(hash_idx));
        req_prev = hash_req;
        if (hash_req && !eng_hang) begin
            eng_cnt++;
            eng_done = (eng_cnt == int'(lat));
        end else begin
            eng_cnt  = 0;
            eng_done = 1'b0;
        end
        spur = force_spur || (spur_en && !hash_req && ($urandom_range(0, 3) == 0));
        junk = {$urandom, $urandom};
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] exp_com [NP];
    logic [DW-1:0] exp_cn = '0, exp_cv = '0, exp_ch = '0;

    task automatic check_results(input string tag);
        for (int i = 0; i < int'(NP); i++)
            check_eq($sformatf("%s_com%0d", tag, i), com_all[i*DW +: DW], exp_com[i]);
        check_eq({tag, "_cn"}, cn, exp_cn);
        check_eq({tag, "_cv"}, cv, exp_cv);
        check_eq({tag, "_ch"}, ch, exp_ch);
    endtask

    task automatic run_round(input bit lc, input int hid, input logic [DW-1:0] comh,
                             input int unsigned l, input logic [DW-1:0] s, input bit keep_start);
        int exp_jobs[$];
        int jb, n, exp_lat;
        lat  = l;
        salt = s;
        for (int i = 0; i < int'(NP); i++)
            if (!lc && i != hid) exp_jobs.push_back(int'(MODE_PARTY) * 256 + i);
        exp_jobs.push_back(int'(MODE_CN) * 256);
        exp_jobs.push_back(int'(MODE_CV) * 256);
        exp_jobs.push_back(int'(MODE_CH) * 256);
        exp_lat = exp_jobs.size() * (int'(l) + 2) + (lc ? 0 : 1);
        @(negedge clk);
        start = 1'b1; in_lc = lc; hidden_j = IW'(hid); com_hidden = comh;
        jb = jobs.size();
        @(posedge clk);
        #1;
        check_eq("busy_after_accept", busy, 1'b1);
        // Inputs change after acceptance; the round must use the latched values.
        hidden_j = IW'($urandom); com_hidden = {$urandom, $urandom}; in_lc = ~lc;
        if (!keep_start) start = 1'b0;
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("latency", n, exp_lat);
        check_eq("busy_in_done", busy, 1'b0);
        check_eq("err_clear", err, 1'b0);
        check_eq("job_count", jobs.size() - jb, exp_jobs.size());
        foreach (exp_jobs[k])
            check_eq($sformatf("job%0d", k), (jb + k < jobs.size()) ? jobs[jb + k] : -1, exp_jobs[k]);
        if (!lc)
            for (int i = 0; i < int'(NP); i++)
                exp_com[i] = (i == hid) ? comh : dig(MODE_PARTY, i);
        exp_cn = dig(MODE_CN, 0);
        exp_cv = dig(MODE_CV, 0);
        exp_ch = dig(MODE_CH, 0);
        check_results("round");
        if (keep_start) begin
            repeat (3) @(posedge clk);
            #1;
            check_eq("done_held", done, 1'b1);
            check_eq("no_restart", jobs.size() - jb, exp_jobs.size());
            @(negedge clk);
            start = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("done_drop", done, 1'b0);
    endtask

    initial begin
        int n, m;
        foreach (exp_com[i]) exp_com[i] = '0;
        #12;
        check_eq("rst_req", hash_req, 1'b0);
        check_eq("rst_mode", hash_mode, 2'd0);
        check_eq("rst_idx", hash_idx, '0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_results("rst");
        @(negedge clk);
        reset = 1'b1;

        // Directed: hidden party 2, then an in-LC round, then start held across done.
        run_round(1'b0, 2, {$urandom, $urandom}, 3, '0, 1'b0);
        run_round(1'b1, 1, {$urandom, $urandom}, 3, '0, 1'b0);
        run_round(1'b0, 0, {$urandom, $urandom}, 2, {$urandom, $urandom}, 1'b1);

        // Spurious done while idle must be ignored.
        @(posedge clk);
        #1 force_spur = 1'b1;
        @(posedge clk);
        #1 force_spur = 1'b0;
        @(posedge clk);
        #1;
        check_eq("spur_idle_busy", busy, 1'b0);
        check_eq("spur_idle_done", done, 1'b0);
        check_results("spur_idle");

        // Randomized rounds, some with spurious done pulses while req is low.
        for (int r = 0; r < 12; r++) begin
            spur_en = ($urandom_range(0, 1) == 1);
            run_round($urandom_range(0, 3) == 0, int'($urandom_range(0, NP - 1)),
                      {$urandom, $urandom}, $urandom_range(1, 5), {$urandom, $urandom},
                      $urandom_range(0, 1) == 1);
        end
        spur_en = 1'b0;

        // Asynchronous reset during the Cv job.
        lat = 4;
        @(negedge clk);
        start = 1'b1; in_lc = 1'b0; hidden_j = IW'($urandom);
        n = 0;
        while (!(hash_req && hash_mode == MODE_CV) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_cv_wait", hash_req && hash_mode == MODE_CV, 1'b1);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_req", hash_req, 1'b0);
        check_eq("arst_mode", hash_mode, 2'd0);
        check_eq("arst_idx", hash_idx, '0);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_done", done, 1'b0);
        check_eq("arst_err", err, 1'b0);
        foreach (exp_com[i]) exp_com[i] = '0;
        exp_cn = '0; exp_cv = '0; exp_ch = '0;
        check_results("arst");
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_round(1'b1, 3, {$urandom, $urandom}, 3, {$urandom, $urandom}, 1'b0);
        run_round(1'b0, 1, {$urandom, $urandom}, 1, {$urandom, $urandom}, 1'b0);

`ifdef ROUND_SEQ_TIMEOUT_EN
        // Engine never answers: the watchdog aborts after TO cycles in WAIT.
        eng_hang = 1'b1;
        @(negedge clk);
        start = 1'b1; in_lc = 1'b1;
        n = 0;
        while (!hash_req && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("to_req_seen", hash_req, 1'b1);
        m = 0;
        while (!done && m < 100) begin
            @(posedge clk);
            #1;
            m++;
        end
        check_eq("to_wait_cycles", m, TO);
        check_eq("to_err", err, 1'b1);
        check_eq("to_done", done, 1'b1);
        check_eq("to_req_low", hash_req, 1'b0);
        check_results("to");
        eng_hang = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("to_err_holds", err, 1'b1);
        run_round(1'b0, 3, {$urandom, $urandom}, 2, {$urandom, $urandom}, 1'b0);
`else
        check_eq("err_tied_low", err, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
